// File: rtl/demux_1to8_deserializer.sv
// demux_1to8_deserializer
//   Serial-to-parallel receiver. Each valid bit is steered into the frame lane
//   selected by the internal lane pointer. After Lanes bits the completed word
//   is loaded onto y_o, and y_valid_o pulses for one cycle. If frame_start_i
//   arrives mid-frame, the partial frame is dropped and frame_err_o pulses.
//
// Ports
//   clk_i          rising-edge clock
//   rst_ni         asynchronous active-low reset
//   din_i          serial data bit
//   din_valid_i    din_i is consumed at this rising edge
//   frame_start_i  current valid bit is lane 0 of a new frame
//   y_o            last completed frame, y_o[k] = bit received on lane k
//   y_valid_o      one-cycle pulse when y_o loads a new frame
//   sel_o          lane the next accepted bit is written to
//   busy_o         a frame is being collected
//   frame_err_o    one-cycle pulse when a restart discards a partial frame
module demux_1to8_deserializer #(
  parameter int unsigned Lanes = 8,
  parameter int unsigned SelW  = $clog2(Lanes)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             din_i,
  input  logic             din_valid_i,
  input  logic             frame_start_i,
  output logic [Lanes-1:0] y_o,
  output logic             y_valid_o,
  output logic [SelW-1:0]  sel_o,
  output logic             busy_o,
  output logic             frame_err_o
);

  typedef enum logic [0:0] {StIdle, StCollect} state_e;

  localparam logic [SelW-1:0] LastLane = SelW'(Lanes - 1);

  state_e           state_q, state_d;
  logic [Lanes-1:0] frame_q, frame_d;
  logic [Lanes-1:0] y_q, y_d;
  logic [SelW-1:0]  sel_q, sel_d;
  logic             y_valid_q, y_valid_d;
  logic             frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    frame_d     = frame_q;
    y_d         = y_q;
    sel_d       = sel_q;
    y_valid_d   = 1'b0;
    frame_err_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Bits arriving without frame_start_i are silently dropped.
        if (din_valid_i && frame_start_i) begin
          frame_d[0] = din_i;
          sel_d      = SelW'(1);
          state_d    = StCollect;
        end
      end
      StCollect: begin
        if (din_valid_i) begin
          if (frame_start_i) begin
            // Restart: the new bit becomes lane 0; y_o keeps the previous frame.
            frame_err_d = 1'b1;
            frame_d[0]  = din_i;
            sel_d       = SelW'(1);
          end else if (sel_q == LastLane) begin
            // Last bit goes straight to y_o so the frame completes on this edge.
            y_d       = {din_i, frame_q[Lanes-2:0]};
            y_valid_d = 1'b1;
            sel_d     = '0;
            state_d   = StIdle;
          end else begin
            frame_d[sel_q] = din_i;
            sel_d          = sel_q + SelW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      frame_q     <= '0;
      y_q         <= '0;
      sel_q       <= '0;
      y_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      frame_q     <= frame_d;
      y_q         <= y_d;
      sel_q       <= sel_d;
      y_valid_q   <= y_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign y_o         = y_q;
  assign y_valid_o   = y_valid_q;
  assign sel_o       = sel_q;
  assign busy_o      = (state_q == StCollect);
  assign frame_err_o = frame_err_q;

endmodule

// File: tb/tb_demux_1to8_deserializer.sv
module tb_demux_1to8_deserializer;

  logic       clk;
  logic       rst_n;
  logic       din;
  logic       din_valid;
  logic       frame_start;
  logic [7:0] y;
  logic       y_valid;
  logic [2:0] sel;
  logic       busy;
  logic       frame_err;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;
  int unsigned exp_err = 0;
  int unsigned obs_err = 0;
  logic [7:0]  exp_y   = 8'h00;
  logic [7:0]  sb_q[$];

  demux_1to8_deserializer #(
    .Lanes(8),
    .SelW (3)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .din_i        (din),
    .din_valid_i  (din_valid),
    .frame_start_i(frame_start),
    .y_o          (y),
    .y_valid_o    (y_valid),
    .sel_o        (sel),
    .busy_o       (busy),
    .frame_err_o  (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard: completed frames are popped when y_valid is observed.
  always @(posedge clk) begin
    #1;
    check_eq("excl", {31'd0, y_valid & frame_err}, 32'd0);
    if (frame_err) obs_err++;
    if (y_valid) begin
      if (sb_q.size() == 0) check_eq("sb_unexpected", 32'd1, 32'd0);
      else                  check_eq("sb_y", {24'd0, y}, {24'd0, sb_q.pop_front()});
    end
  end

  // Drive one cycle of inputs, then return 1 time unit after the sampling edge.
  task automatic send_bit(input logic v, input logic fs, input logic d);
    din_valid   = v;
    frame_start = fs;
    din         = d;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] w, input bit restart,
                            input int gap_a, input int gap_b, input int gap_len);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) sb_q.push_back(w);
      send_bit(1'b1, i == 0, w[i]);
      if (restart && i == 0) exp_err++;
      check_eq("sel",       {29'd0, sel},       (i + 1) % 8);
      check_eq("busy",      {31'd0, busy},      {31'd0, i != 7});
      check_eq("y_valid",   {31'd0, y_valid},   {31'd0, i == 7});
      check_eq("frame_err", {31'd0, frame_err}, {31'd0, restart && i == 0});
      check_eq("y",         {24'd0, y},         {24'd0, (i == 7) ? w : exp_y});
      if (i == gap_a || i == gap_b) begin
        for (int g = 0; g < gap_len; g++) begin
          send_bit(1'b0, 1'($urandom), 1'($urandom));
          check_eq("gap_sel",  {29'd0, sel},  i + 1);
          check_eq("gap_busy", {31'd0, busy}, 32'd1);
          check_eq("gap_yv",   {31'd0, y_valid | frame_err}, 32'd0);
        end
      end
    end
    exp_y = w;
  endtask

  // Starts a frame from IDLE and stops after n bits.
  task automatic send_partial(input logic [7:0] w, input int n);
    for (int i = 0; i < n; i++) begin
      send_bit(1'b1, i == 0, w[i]);
      check_eq("p_sel",  {29'd0, sel},  i + 1);
      check_eq("p_busy", {31'd0, busy}, 32'd1);
      check_eq("p_flag", {31'd0, y_valid | frame_err}, 32'd0);
    end
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check_eq({tag, "_sel"},  {29'd0, sel},  32'd0);
    check_eq({tag, "_yv"},   {31'd0, y_valid}, 32'd0);
    check_eq({tag, "_y"},    {24'd0, y},    {24'd0, exp_y});
  endtask

  initial begin
    rst_n       = 1'b0;
    din         = 1'b0;
    din_valid   = 1'b0;
    frame_start = 1'b0;
    #12;
    check_quiet("rst");
    check_eq("rst_ferr", {31'd0, frame_err}, 32'd0);
    #5 rst_n = 1'b1;

    // Plain frame, then y_valid must drop.
    send_frame(8'h48, 1'b0, -1, -1, 0);
    send_bit(1'b0, 1'b0, 1'b0);
    check_quiet("post48");

    // Frame with 3-cycle gaps after the 2nd and 5th bits.
    send_frame(8'h48, 1'b0, 1, 4, 3);
    send_bit(1'b0, 1'b0, 1'b0);
    check_quiet("gap48");

    // Back-to-back frames with no bubble.
    send_frame(8'hA5, 1'b0, -1, -1, 0);
    send_frame(8'h3C, 1'b0, -1, -1, 0);

    // Restart after 4 bits, then restart with the pointer on the last lane.
    send_partial(8'h0F, 4);
    send_frame(8'hFF, 1'b1, -1, -1, 0);
    send_partial(8'h55, 7);
    send_frame(8'h96, 1'b1, -1, -1, 0);
    send_bit(1'b0, 1'b0, 1'b0);

    // Valid without frame_start, and frame_start without valid, while idle.
    for (int k = 0; k < 4; k++) begin
      send_bit(1'b1, 1'b0, 1'($urandom));
      check_quiet("idle_v");
    end
    for (int k = 0; k < 3; k++) begin
      send_bit(1'b0, 1'b1, 1'($urandom));
      check_quiet("idle_fs");
    end

    // Asynchronous reset mid-frame.
    send_partial(8'h48, 5);
    #2 rst_n = 1'b0;
    #1;
    exp_y = 8'h00;
    check_quiet("arst");
    check_eq("arst_ferr", {31'd0, frame_err}, 32'd0);
    @(negedge clk);
    din_valid = 1'b0;
    rst_n     = 1'b1;
    send_frame(8'h48, 1'b0, -1, -1, 0);
    send_bit(1'b0, 1'b0, 1'b0);
    check_quiet("end");

    check_eq("err_count", obs_err, exp_err);
    check_eq("sb_empty", sb_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
